video_mode_sequencer: RTL and testbench
=======================================

# video_mode_sequencer

Sequences the HDMI output path across Atari ST video mode changes. The block sits between `video_analyzer` and the scandoubler/`hdmi` pair in the `clk_pixel` domain. It qualifies the analyzer's raw mode over several frames, then commits it to the datapath. It holds HDMI in reset and mutes audio while the mode is unsettled, and releases the reset exactly on a vsync edge. A vsync watchdog drops the path back to reset when the video source stops.

## Interface
Parameters:
- `STABLE_FRAMES`, 4 — consecutive identical-mode frames needed to commit; legal range 2..15.
- `MUTE_FRAMES`, 8 — frames audio stays muted after lock; legal range 0..255.
- `TIMEOUT_CYCLES`, 1000000 — clocks without a vsync edge before lock is dropped (31.25 ms at 32 MHz).

Ports:
- `clk` — input, 1 — pixel clock (32 MHz).
- `resetn` — input, 1 — asynchronous, active-low reset.
- `vs_in_n` — input, 1 — shifter vsync, active low, synchronous to `clk`.
- `mode_in` — input, 2 — raw mode from `video_analyzer`.
- `mode_out` — output, 2 — committed mode to `hdmi.stmode`.
- `bypass` — output, 1 — `mode_out == MODE_MONO`; drives the scandoubler bypass.
- `hdmi_reset` — output, 1 — high while the path is unlocked; drives `hdmi.reset`.
- `audio_mute` — output, 1 — high to force the audio samples to zero.
- `locked` — output, 1 — high in LOCKED.

## Operation
- Frame event (`vs_fall`): `vs_in_n == 0` and the previous-cycle sample `vs_d == 1`. `vs_d` resets to 1.
- Mode codes: 0 = PAL, 1 = NTSC, 2 = MONO, 3 = UNKNOWN. UNKNOWN is never committed.
- State UNLOCKED:
  - On `vs_fall` with `mode_in != 3`: `cand <= mode_in`, `cnt <= 1`, go to QUALIFY.
  - On `vs_fall` with `mode_in == 3`: stay in UNLOCKED.
- State QUALIFY, on `vs_fall`:
  - `mode_in == 3`: go to UNLOCKED.
  - `mode_in != cand`: `cand <= mode_in`, `cnt <= 1`.
  - Otherwise, if `cnt + 1 == STABLE_FRAMES`: `mode_out <= cand`, `hdmi_reset <= 0`, `mute_cnt <= MUTE_FRAMES`, go to LOCKED.
  - Otherwise: `cnt <= cnt + 1`.
- State LOCKED, on `vs_fall`:
  - `mode_in != mode_out`: `hdmi_reset <= 1`, `audio_mute <= 1`, `mute_cnt <= 0`.
    - If `mode_in == 3`, go to UNLOCKED.
    - Otherwise `cand <= mode_in`, `cnt <= 1`, go to QUALIFY.
  - Match with `mute_cnt != 0`: decrement `mute_cnt`.
- `audio_mute` is registered. It is 1 in UNLOCKED and QUALIFY. In LOCKED it follows `mute_cnt != 0`, including the `MUTE_FRAMES == 0` case.
- Watchdog:
  - Timer is held at 0 in UNLOCKED and counts in QUALIFY and LOCKED.
  - `vs_fall` clears the timer.
  - On reaching `TIMEOUT_CYCLES-1`: go to UNLOCKED, `hdmi_reset <= 1`, `audio_mute <= 1`, timer cleared.
- `mode_out` holds the last committed value through QUALIFY and UNLOCKED. It changes only on the commit edge.
- Widths: `cnt` 4 bits, `mute_cnt` 8 bits, timer `$clog2(TIMEOUT_CYCLES)` bits. No counter wraps; the watchdog timer saturates by transition.

## Timing
- Reset values: `mode_out = 0`, `bypass = 0`, `hdmi_reset = 1`, `audio_mute = 1`, `locked = 0`, state UNLOCKED.
- All outputs are registered and change on the clock edge that ends the `vs_fall` cycle (1-cycle latency from the falling edge of `vs_in_n`).
- The commit sets `mode_out`, clears `hdmi_reset` and raises `locked` in the same cycle.
- A commit occurs on the `STABLE_FRAMES`-th matching `vs_fall`, counting the capture edge.
- Simultaneous `vs_fall` and watchdog expiry: `vs_fall` wins and the timer is cleared.
- `resetn` asserted mid-operation: outputs go to reset values immediately (asynchronously). After release, the block restarts in UNLOCKED.

## Structure
- Shared package `video_pkg`:
  - Mode constants `MODE_PAL`, `MODE_NTSC`, `MODE_MONO`, `MODE_UNKNOWN`.
  - State enum `seq_state_t` with values UNLOCKED, QUALIFY, LOCKED.
- Sub-module `vsync_watchdog`:
  - Contains the `vs_d` register, `vs_fall` detection and the timeout counter.
  - Inputs: `clk`, `resetn`, `vs_in_n`, `run`.
  - Outputs: `vs_fall`, `timeout`.
- All sequencing lives in the top FSM.

## Test plan
- Reset, then `mode_in = 0` with 5 vsync edges → `hdmi_reset` falls, `locked` rises and `mode_out = 0` one cycle after the 4th edge. `audio_mute` clears after 8 further edges.
- Locked PAL, then `mode_in = 2` → on the next edge `hdmi_reset = 1` and `audio_mute = 1`. After 4 edges total at mode 2: `mode_out = 2`, `bypass = 1`.
- Mode sequence in QUALIFY of 1,1,0,0,0,0 → commit occurs on the 6th edge with `mode_out = 0`, never 1.
- Locked, then `vs_in_n` held high for 1,000,000 cycles → `hdmi_reset = 1`, `locked = 0`. Restarting vsync relocks after 4 edges.
- `vs_fall` placed on the exact timeout cycle → stays LOCKED.
- `resetn` pulsed mid-QUALIFY → immediate reset values, and requalification restarts from a count of 1. `mode_in = 3` while LOCKED → state goes to UNLOCKED and `mode_out` is retained.

Source files
------------

// File: rtl/video_pkg.sv
// Shared definitions for the Atari ST video path: mode codes and the
// sequencer state encoding.
package video_pkg;

    localparam logic [1:0] MODE_PAL     = 2'd0;
    localparam logic [1:0] MODE_NTSC    = 2'd1;
    localparam logic [1:0] MODE_MONO    = 2'd2;
    localparam logic [1:0] MODE_UNKNOWN = 2'd3;

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        QUALIFY  = 2'd1,
        LOCKED   = 2'd2
    } seq_state_t;

    function automatic logic is_known_mode(input logic [1:0] mode);
        return mode != MODE_UNKNOWN;
    endfunction

endpackage

// File: rtl/vsync_watchdog.sv
// Vsync falling-edge detector plus a no-vsync watchdog timer that only runs
// while the sequencer is qualifying or locked.
module vsync_watchdog #(
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic clk,
    input  logic resetn,
    input  logic vs_in_n,
    input  logic run,
    output logic vs_fall,
    output logic timeout
);

    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TERMINAL = TW'(TIMEOUT_CYCLES - 1);

    logic          r_vs_d;
    logic [TW-1:0] r_timer;
    logic          w_terminal;

    assign vs_fall    = ~vs_in_n & r_vs_d;
    assign w_terminal = (r_timer == TERMINAL);
    // A frame edge on the terminal cycle beats the expiry.
    assign timeout    = run & w_terminal & ~vs_fall;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_vs_d  <= 1'b1;
            r_timer <= '0;
        end else begin
            r_vs_d <= vs_in_n;
            if (!run || vs_fall || w_terminal) begin
                r_timer <= '0;
            end else begin
                r_timer <= r_timer + 1'b1;
            end
        end
    end

endmodule

// File: rtl/video_mode_sequencer.sv
// Qualifies the analyzer mode over several frames, commits it to the HDMI
// path, and holds HDMI reset / audio mute while the mode is unsettled.
module video_mode_sequencer
    import video_pkg::*;
#(
    parameter int STABLE_FRAMES  = 4,
    parameter int MUTE_FRAMES    = 8,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       vs_in_n,
    input  logic [1:0] mode_in,
    output logic [1:0] mode_out,
    output logic       bypass,
    output logic       hdmi_reset,
    output logic       audio_mute,
    output logic       locked
);

    seq_state_t r_state, w_state_nx;
    logic [1:0] r_cand, w_cand_nx;
    logic [3:0] r_cnt, w_cnt_nx;
    logic [7:0] r_mute_cnt, w_mute_cnt_nx;
    logic [1:0] r_mode_out, w_mode_out_nx;
    logic       r_bypass;
    logic       r_hdmi_reset, w_hdmi_reset_nx;
    logic       r_audio_mute, w_audio_mute_nx;
    logic       w_vs_fall;
    logic       w_timeout;
    logic       w_run;

    assign w_run = (r_state != UNLOCKED);

    vsync_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_vsync_watchdog (
        .clk     (clk),
        .resetn  (resetn),
        .vs_in_n (vs_in_n),
        .run     (w_run),
        .vs_fall (w_vs_fall),
        .timeout (w_timeout)
    );

    always_comb begin
        w_state_nx      = r_state;
        w_cand_nx       = r_cand;
        w_cnt_nx        = r_cnt;
        w_mute_cnt_nx   = r_mute_cnt;
        w_mode_out_nx   = r_mode_out;
        w_hdmi_reset_nx = r_hdmi_reset;
        w_audio_mute_nx = r_audio_mute;

        case (r_state)
            UNLOCKED: begin
                w_hdmi_reset_nx = 1'b1;
                w_audio_mute_nx = 1'b1;
                if (w_vs_fall && is_known_mode(mode_in)) begin
                    w_cand_nx  = mode_in;
                    w_cnt_nx   = 4'd1;
                    w_state_nx = QUALIFY;
                end
            end

            QUALIFY: begin
                w_hdmi_reset_nx = 1'b1;
                w_audio_mute_nx = 1'b1;
                if (w_vs_fall) begin
                    if (!is_known_mode(mode_in)) begin
                        w_state_nx = UNLOCKED;
                    end else if (mode_in != r_cand) begin
                        w_cand_nx = mode_in;
                        w_cnt_nx  = 4'd1;
                    end else if ((5'(r_cnt) + 5'd1) == 5'(STABLE_FRAMES)) begin
                        w_mode_out_nx   = r_cand;
                        w_hdmi_reset_nx = 1'b0;
                        w_mute_cnt_nx   = 8'(MUTE_FRAMES);
                        w_audio_mute_nx = (MUTE_FRAMES != 0);
                        w_state_nx      = LOCKED;
                    end else begin
                        w_cnt_nx = r_cnt + 4'd1;
                    end
                end else if (w_timeout) begin
                    w_state_nx = UNLOCKED;
                end
            end

            LOCKED: begin
                if (w_vs_fall) begin
                    if (mode_in != r_mode_out) begin
                        w_hdmi_reset_nx = 1'b1;
                        w_audio_mute_nx = 1'b1;
                        w_mute_cnt_nx   = 8'd0;
                        if (!is_known_mode(mode_in)) begin
                            w_state_nx = UNLOCKED;
                        end else begin
                            w_cand_nx  = mode_in;
                            w_cnt_nx   = 4'd1;
                            w_state_nx = QUALIFY;
                        end
                    end else if (r_mute_cnt != 8'd0) begin
                        w_mute_cnt_nx   = r_mute_cnt - 8'd1;
                        w_audio_mute_nx = (r_mute_cnt != 8'd1);
                    end
                end else if (w_timeout) begin
                    w_hdmi_reset_nx = 1'b1;
                    w_audio_mute_nx = 1'b1;
                    w_mute_cnt_nx   = 8'd0;
                    w_state_nx      = UNLOCKED;
                end
            end

            default: begin
                w_hdmi_reset_nx = 1'b1;
                w_audio_mute_nx = 1'b1;
                w_state_nx      = UNLOCKED;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state      <= UNLOCKED;
            r_cand       <= MODE_PAL;
            r_cnt        <= 4'd0;
            r_mute_cnt   <= 8'd0;
            r_mode_out   <= MODE_PAL;
            r_bypass     <= 1'b0;
            r_hdmi_reset <= 1'b1;
            r_audio_mute <= 1'b1;
        end else begin
            r_state      <= w_state_nx;
            r_cand       <= w_cand_nx;
            r_cnt        <= w_cnt_nx;
            r_mute_cnt   <= w_mute_cnt_nx;
            r_mode_out   <= w_mode_out_nx;
            r_bypass     <= (w_mode_out_nx == MODE_MONO);
            r_hdmi_reset <= w_hdmi_reset_nx;
            r_audio_mute <= w_audio_mute_nx;
        end
    end

    assign mode_out   = r_mode_out;
    assign bypass     = r_bypass;
    assign hdmi_reset = r_hdmi_reset;
    assign audio_mute = r_audio_mute;
    assign locked     = (r_state == LOCKED);

endmodule

// File: tb/tb_video_mode_sequencer.sv
// Directed bench for video_mode_sequencer with a shortened watchdog timeout.
module tb_video_mode_sequencer;

    localparam int T = 200;

    logic       clk;
    logic       resetn;
    logic       vs_in_n;
    logic [1:0] mode_in;
    logic [1:0] mode_out;
    logic       bypass;
    logic       hdmi_reset;
    logic       audio_mute;
    logic       locked;

    int n_pass;
    int n_total;

    video_mode_sequencer #(
        .STABLE_FRAMES (4),
        .MUTE_FRAMES   (8),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .vs_in_n   (vs_in_n),
        .mode_in   (mode_in),
        .mode_out  (mode_out),
        .bypass    (bypass),
        .hdmi_reset(hdmi_reset),
        .audio_mute(audio_mute),
        .locked    (locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One-cycle vsync low pulse; returns 1 ns after the edge that registers it.
    task automatic vs_edge(input logic [1:0] m);
        @(posedge clk); #1;
        mode_in = m;
        vs_in_n = 1'b0;
        @(posedge clk); #1;
        vs_in_n = 1'b1;
    endtask

    task automatic gap(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic edges(input logic [1:0] m, input int n);
        for (int i = 0; i < n; i++) begin
            vs_edge(m);
            gap(4);
        end
    endtask

    task automatic do_reset();
        resetn  = 1'b0;
        vs_in_n = 1'b1;
        mode_in = 2'd0;
        gap(3);
        resetn = 1'b1;
        gap(2);
    endtask

    task automatic test_reset();
        do_reset();
        n_total++; if (mode_out !== 2'd0) $display("FAIL reset_mode_out got=%0d exp=0", mode_out); else n_pass++;
        n_total++; if (bypass !== 1'b0) $display("FAIL reset_bypass got=%b exp=0", bypass); else n_pass++;
        n_total++; if (hdmi_reset !== 1'b1) $display("FAIL reset_hdmi_reset got=%b exp=1", hdmi_reset); else n_pass++;
        n_total++; if (audio_mute !== 1'b1) $display("FAIL reset_audio_mute got=%b exp=1", audio_mute); else n_pass++;
        n_total++; if (locked !== 1'b0) $display("FAIL reset_locked got=%b exp=0", locked); else n_pass++;
    endtask

    task automatic test_lock_pal();
        edges(2'd0, 3);
        n_total++; if (locked !== 1'b0) $display("FAIL pal_early_locked got=%b exp=0", locked); else n_pass++;
        n_total++; if (hdmi_reset !== 1'b1) $display("FAIL pal_early_hdmi got=%b exp=1", hdmi_reset); else n_pass++;
        vs_edge(2'd0);
        n_total++; if (locked !== 1'b1) $display("FAIL pal_commit_locked got=%b exp=1", locked); else n_pass++;
        n_total++; if (hdmi_reset !== 1'b0) $display("FAIL pal_commit_hdmi got=%b exp=0", hdmi_reset); else n_pass++;
        n_total++; if (mode_out !== 2'd0) $display("FAIL pal_commit_mode got=%0d exp=0", mode_out); else n_pass++;
        n_total++; if (audio_mute !== 1'b1) $display("FAIL pal_commit_mute got=%b exp=1", audio_mute); else n_pass++;
        gap(4);
        edges(2'd0, 7);
        n_total++; if (audio_mute !== 1'b1) $display("FAIL pal_mute_7 got=%b exp=1", audio_mute); else n_pass++;
        vs_edge(2'd0);
        n_total++; if (audio_mute !== 1'b0) $display("FAIL pal_mute_8 got=%b exp=0", audio_mute); else n_pass++;
        n_total++; if (locked !== 1'b1) $display("FAIL pal_still_locked got=%b exp=1", locked); else n_pass++;
        gap(4);
    endtask

    task automatic test_mode_change();
        vs_edge(2'd2);
        n_total++; if (hdmi_reset !== 1'b1) $display("FAIL chg_hdmi got=%b exp=1", hdmi_reset); else n_pass++;
        n_total++; if (audio_mute !== 1'b1) $display("FAIL chg_mute got=%b exp=1", audio_mute); else n_pass++;
        n_total++; if (locked !== 1'b0) $display("FAIL chg_locked got=%b exp=0", locked); else n_pass++;
        n_total++; if (mode_out !== 2'd0) $display("FAIL chg_mode_held got=%0d exp=0", mode_out); else n_pass++;
        gap(4);
        edges(2'd2, 2);
        n_total++; if (locked !== 1'b0) $display("FAIL chg_3_locked got=%b exp=0", locked); else n_pass++;
        vs_edge(2'd2);
        n_total++; if (mode_out !== 2'd2) $display("FAIL chg_mode_out got=%0d exp=2", mode_out); else n_pass++;
        n_total++; if (bypass !== 1'b1) $display("FAIL chg_bypass got=%b exp=1", bypass); else n_pass++;
        n_total++; if (locked !== 1'b1) $display("FAIL chg_relock got=%b exp=1", locked); else n_pass++;
        gap(4);
    endtask

    task automatic test_requalify();
        logic [1:0] seq [6];
        int         saw_ntsc;
        seq = '{2'd1, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0};
        saw_ntsc = 0;
        for (int i = 0; i < 5; i++) begin
            vs_edge(seq[i]);
            if (mode_out == 2'd1 || locked) saw_ntsc++;
            gap(4);
        end
        n_total++; if (saw_ntsc !== 0) $display("FAIL requal_early_commit got=%0d exp=0", saw_ntsc); else n_pass++;
        n_total++; if (mode_out !== 2'd2) $display("FAIL requal_mode_held got=%0d exp=2", mode_out); else n_pass++;
        vs_edge(seq[5]);
        n_total++; if (locked !== 1'b1) $display("FAIL requal_locked got=%b exp=1", locked); else n_pass++;
        n_total++; if (mode_out !== 2'd0) $display("FAIL requal_mode got=%0d exp=0", mode_out); else n_pass++;
        n_total++; if (bypass !== 1'b0) $display("FAIL requal_bypass got=%b exp=0", bypass); else n_pass++;
        gap(4);
    endtask

    task automatic test_watchdog();
        vs_edge(2'd0);
        repeat (T - 1) @(posedge clk);
        #1;
        n_total++; if (locked !== 1'b1) $display("FAIL wd_before got=%b exp=1", locked); else n_pass++;
        @(posedge clk); #1;
        n_total++; if (locked !== 1'b0) $display("FAIL wd_locked got=%b exp=0", locked); else n_pass++;
        n_total++; if (hdmi_reset !== 1'b1) $display("FAIL wd_hdmi got=%b exp=1", hdmi_reset); else n_pass++;
        n_total++; if (audio_mute !== 1'b1) $display("FAIL wd_mute got=%b exp=1", audio_mute); else n_pass++;
        n_total++; if (mode_out !== 2'd0) $display("FAIL wd_mode_held got=%0d exp=0", mode_out); else n_pass++;
        gap(T + 20);
        n_total++; if (locked !== 1'b0) $display("FAIL wd_idle got=%b exp=0", locked); else n_pass++;
        edges(2'd0, 3);
        n_total++; if (locked !== 1'b0) $display("FAIL wd_relock_3 got=%b exp=0", locked); else n_pass++;
        vs_edge(2'd0);
        n_total++; if (locked !== 1'b1) $display("FAIL wd_relock_4 got=%b exp=1", locked); else n_pass++;
        gap(4);
    endtask

    task automatic test_timeout_race();
        vs_edge(2'd0);
        repeat (T - 2) @(posedge clk);
        vs_edge(2'd0);
        n_total++; if (locked !== 1'b1) $display("FAIL race_locked got=%b exp=1", locked); else n_pass++;
        n_total++; if (hdmi_reset !== 1'b0) $display("FAIL race_hdmi got=%b exp=0", hdmi_reset); else n_pass++;
        repeat (T - 1) @(posedge clk);
        #1;
        n_total++; if (locked !== 1'b1) $display("FAIL race_timer_cleared got=%b exp=1", locked); else n_pass++;
        edges(2'd0, 1);
    endtask

    task automatic test_reset_mid_qualify();
        edges(2'd2, 4);
        n_total++; if (bypass !== 1'b1) $display("FAIL rq_mono_lock got=%b exp=1", bypass); else n_pass++;
        edges(2'd1, 2);
        #2;
        resetn = 1'b0;
        #1;
        n_total++; if (mode_out !== 2'd0) $display("FAIL rq_async_mode got=%0d exp=0", mode_out); else n_pass++;
        n_total++; if (bypass !== 1'b0) $display("FAIL rq_async_bypass got=%b exp=0", bypass); else n_pass++;
        n_total++; if (hdmi_reset !== 1'b1) $display("FAIL rq_async_hdmi got=%b exp=1", hdmi_reset); else n_pass++;
        n_total++; if (audio_mute !== 1'b1) $display("FAIL rq_async_mute got=%b exp=1", audio_mute); else n_pass++;
        gap(2);
        resetn = 1'b1;
        gap(2);
        edges(2'd1, 3);
        n_total++; if (locked !== 1'b0) $display("FAIL rq_restart_3 got=%b exp=0", locked); else n_pass++;
        vs_edge(2'd1);
        n_total++; if (locked !== 1'b1) $display("FAIL rq_restart_4 got=%b exp=1", locked); else n_pass++;
        n_total++; if (mode_out !== 2'd1) $display("FAIL rq_mode got=%0d exp=1", mode_out); else n_pass++;
        gap(4);
    endtask

    task automatic test_unknown();
        vs_edge(2'd3);
        n_total++; if (locked !== 1'b0) $display("FAIL unk_locked got=%b exp=0", locked); else n_pass++;
        n_total++; if (hdmi_reset !== 1'b1) $display("FAIL unk_hdmi got=%b exp=1", hdmi_reset); else n_pass++;
        n_total++; if (mode_out !== 2'd1) $display("FAIL unk_mode_held got=%0d exp=1", mode_out); else n_pass++;
        gap(4);
        edges(2'd3, 5);
        n_total++; if (locked !== 1'b0) $display("FAIL unk_never_commit got=%b exp=0", locked); else n_pass++;
        n_total++; if (mode_out !== 2'd1) $display("FAIL unk_mode_kept got=%0d exp=1", mode_out); else n_pass++;
        edges(2'd1, 4);
        n_total++; if (locked !== 1'b1) $display("FAIL unk_relock got=%b exp=1", locked); else n_pass++;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        resetn  = 1'b0;
        vs_in_n = 1'b1;
        mode_in = 2'd0;
        test_reset();
        test_lock_pal();
        test_mode_change();
        test_requalify();
        test_watchdog();
        test_timeout_race();
        test_reset_mid_qualify();
        test_unknown();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
